// File: rtl/blit_pkg.sv
// blit_pkg: definitions shared by the sprite blitter sources.
//   ADDR_W        : word address width of the character and framebuffer RAMs
//   PIX_W         : pixel width (24-bit RGB)
//   COORD_W       : signed destination coordinate width (10-bit origin plus 8-bit offset)
//   FB_WIDTH_DEF  : default framebuffer width in pixels
//   FB_HEIGHT_DEF : default framebuffer height in pixels
//   blit_state_e  : blitter FSM states
package blit_pkg;

    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned PIX_W   = 24;
    localparam int unsigned COORD_W = 11;

    localparam int FB_WIDTH_DEF  = 240;
    localparam int FB_HEIGHT_DEF = 160;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } blit_state_e;

endpackage

// File: rtl/blit_pixel_filter.sv
// blit_pixel_filter: decides whether a fetched pixel is written to the framebuffer.
// A pixel is written when it is pending, its destination lies inside the
// framebuffer, and (with BLIT_TRANSPARENCY_EN defined) its colour is not the key.
// Ports:
//   pix_valid : a pixel fetched last cycle is present this cycle
//   pix_x     : signed destination x of that pixel
//   pix_y     : signed destination y of that pixel
//   pix_data  : colour of that pixel (character RAM read data)
//   pix_we    : framebuffer write enable
// Macro BLIT_TRANSPARENCY_EN: when defined, TRANSPARENT_KEY pixels are skipped.
module blit_pixel_filter
    import blit_pkg::*;
#(
    parameter int              FB_WIDTH        = FB_WIDTH_DEF,
    parameter int              FB_HEIGHT       = FB_HEIGHT_DEF,
    parameter logic [PIX_W-1:0] TRANSPARENT_KEY = 24'hFF00FF
) (
    input  logic                      pix_valid,
    input  logic signed [COORD_W-1:0] pix_x,
    input  logic signed [COORD_W-1:0] pix_y,
    input  logic        [PIX_W-1:0]   pix_data,
    output logic                      pix_we
);

    localparam logic signed [COORD_W-1:0] XLim = COORD_W'(FB_WIDTH);
    localparam logic signed [COORD_W-1:0] YLim = COORD_W'(FB_HEIGHT);

    logic x_ok;
    logic y_ok;
    logic colour_ok;

    // Sign bit clear means non-negative; signed upper compare avoids row wrap.
    assign x_ok = !pix_x[COORD_W-1] && (pix_x < XLim);
    assign y_ok = !pix_y[COORD_W-1] && (pix_y < YLim);

`ifdef BLIT_TRANSPARENCY_EN
    assign colour_ok = (pix_data != TRANSPARENT_KEY);
`else
    logic unused_colour;
    assign unused_colour = ^{pix_data, TRANSPARENT_KEY};
    assign colour_ok     = 1'b1;
`endif

    assign pix_we = pix_valid && x_ok && y_ok && colour_ok;

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a sprite from a character sheet into a framebuffer.
// One character RAM read is issued per cycle in raster order; each pixel is
// written one cycle later, clipped to the framebuffer (and optionally keyed out).
// Ports:
//   Clk, Reset         : clock, asynchronous active-high reset
//   start              : blit request, sampled only when idle
//   src_base           : sheet word address of the sprite top-left
//   sprite_w/sprite_h  : sprite size in pixels (zero means nothing to draw)
//   dst_x/dst_y        : signed framebuffer position of the sprite top-left
//   char_read_address  : character RAM read address (data returns next cycle)
//   char_data          : character RAM read data
//   fb_write_address   : framebuffer write address
//   fb_data / fb_we    : framebuffer write data / enable
//   busy / done        : operation in progress / one-cycle completion pulse
// Macro BLIT_TRANSPARENCY_EN: when defined, TRANSPARENT_KEY pixels are not written.
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int               FB_WIDTH        = FB_WIDTH_DEF,
    parameter int               FB_HEIGHT       = FB_HEIGHT_DEF,
    parameter int               SHEET_WIDTH     = 256,
    parameter logic [PIX_W-1:0] TRANSPARENT_KEY = 24'hFF00FF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [7:0]        sprite_w,
    input  logic [7:0]        sprite_h,
    input  logic [9:0]        dst_x,
    input  logic [9:0]        dst_y,
    output logic [ADDR_W-1:0] char_read_address,
    input  logic [PIX_W-1:0]  char_data,
    output logic [ADDR_W-1:0] fb_write_address,
    output logic [PIX_W-1:0]  fb_data,
    output logic              fb_we,
    output logic              busy,
    output logic              done
);

    blit_state_e state_q;

    logic [7:0]                w_q;
    logic [7:0]                h_q;
    logic [7:0]                col_q;
    logic [7:0]                row_q;
    logic [ADDR_W-1:0]         src_row_q;
    logic [ADDR_W-1:0]         fb_row_q;
    logic [ADDR_W-1:0]         fb_cur_q;
    logic signed [COORD_W-1:0] dx0_q;
    logic signed [COORD_W-1:0] dx_q;
    logic signed [COORD_W-1:0] dy_q;

    // Write-side pipeline stage: the pixel whose read was issued last cycle.
    logic                      pend_q;
    logic signed [COORD_W-1:0] px_q;
    logic signed [COORD_W-1:0] py_q;

    logic signed [31:0] dst_x_ext;
    logic signed [31:0] dst_y_ext;
    logic signed [31:0] fb_start;
    logic [ADDR_W-1:0]  fb_start_addr;

    assign dst_x_ext = 32'(signed'(dst_x));
    assign dst_y_ext = 32'(signed'(dst_y));
    // Constant-coefficient product, evaluated once per blit to seed the row
    // accumulator; modulo-2^19 wrap is harmless since off-screen pixels are clipped.
    assign fb_start      = dst_y_ext * FB_WIDTH + dst_x_ext;
    assign fb_start_addr = ADDR_W'(fb_start);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q           <= StIdle;
            w_q               <= '0;
            h_q               <= '0;
            col_q             <= '0;
            row_q             <= '0;
            src_row_q         <= '0;
            fb_row_q          <= '0;
            fb_cur_q          <= '0;
            dx0_q             <= '0;
            dx_q              <= '0;
            dy_q              <= '0;
            pend_q            <= 1'b0;
            px_q              <= '0;
            py_q              <= '0;
            char_read_address <= '0;
            fb_write_address  <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            done   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        w_q      <= sprite_w;
                        h_q      <= sprite_h;
                        col_q    <= '0;
                        row_q    <= '0;
                        dx0_q    <= COORD_W'(signed'(dst_x));
                        dx_q     <= COORD_W'(signed'(dst_x));
                        dy_q     <= COORD_W'(signed'(dst_y));
                        fb_row_q <= fb_start_addr;
                        fb_cur_q <= fb_start_addr;
                        busy     <= 1'b1;
                        if ((sprite_w == 8'd0) || (sprite_h == 8'd0)) begin
                            state_q <= StDrain;
                        end else begin
                            state_q           <= StRun;
                            src_row_q         <= src_base;
                            char_read_address <= src_base;
                        end
                    end
                end
                StRun: begin
                    pend_q           <= 1'b1;
                    px_q             <= dx_q;
                    py_q             <= dy_q;
                    fb_write_address <= fb_cur_q;
                    if (col_q == w_q - 8'd1) begin
                        col_q <= '0;
                        if (row_q == h_q - 8'd1) begin
                            // Last read issued; address holds its final value.
                            state_q <= StDrain;
                        end else begin
                            row_q             <= row_q + 8'd1;
                            src_row_q         <= src_row_q + ADDR_W'(SHEET_WIDTH);
                            char_read_address <= src_row_q + ADDR_W'(SHEET_WIDTH);
                            fb_row_q          <= fb_row_q + ADDR_W'(FB_WIDTH);
                            fb_cur_q          <= fb_row_q + ADDR_W'(FB_WIDTH);
                            dx_q              <= dx0_q;
                            dy_q              <= dy_q + COORD_W'(1);
                        end
                    end else begin
                        col_q             <= col_q + 8'd1;
                        char_read_address <= char_read_address + ADDR_W'(1);
                        fb_cur_q          <= fb_cur_q + ADDR_W'(1);
                        dx_q              <= dx_q + COORD_W'(1);
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    done    <= 1'b1;
                end
                StDone: begin
                    // start is not looked at here, so one coincident with done is dropped.
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read data arrives the cycle after its address, so it is forwarded directly.
    assign fb_data = pend_q ? char_data : '0;

    blit_pixel_filter #(
        .FB_WIDTH        (FB_WIDTH),
        .FB_HEIGHT       (FB_HEIGHT),
        .TRANSPARENT_KEY (TRANSPARENT_KEY)
    ) u_filter (
        .pix_valid (pend_q),
        .pix_x     (px_q),
        .pix_y     (py_q),
        .pix_data  (char_data),
        .pix_we    (fb_we)
    );

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed self-checking bench for sprite_blitter.
// Cycle 0 is the cycle in which start is presented; cycle c is observed at
// the falling edge after the c-th rising edge that follows.
module tb_sprite_blitter;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [18:0] src_base;
    logic [7:0]  sprite_w;
    logic [7:0]  sprite_h;
    logic [9:0]  dst_x;
    logic [9:0]  dst_y;
    logic [18:0] char_read_address;
    logic [23:0] char_data;
    logic [18:0] fb_write_address;
    logic [23:0] fb_data;
    logic        fb_we;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [18:0] got_a[$];
    logic [23:0] got_d[$];
    logic [18:0] exp_a[$];
    logic [23:0] exp_d[$];
    int done_cyc;
    int done_cnt;
    int busy_first;
    int busy_last;

    sprite_blitter u_dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .start             (start),
        .src_base          (src_base),
        .sprite_w          (sprite_w),
        .sprite_h          (sprite_h),
        .dst_x             (dst_x),
        .dst_y             (dst_y),
        .char_read_address (char_read_address),
        .char_data         (char_data),
        .fb_write_address  (fb_write_address),
        .fb_data           (fb_data),
        .fb_we             (fb_we),
        .busy              (busy),
        .done              (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Sheet contents: word 1 is the transparent key, every other word is unique.
    function automatic logic [23:0] pix_of(input logic [18:0] a);
        if (a == 19'd1) return 24'hFF00FF;
        return {5'd0, a} ^ 24'hA50000;
    endfunction

    // Synchronous character RAM: data valid the cycle after the address.
    always @(posedge Clk) char_data <= pix_of(char_read_address);

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic add_exp(input int fb_addr, input int src_addr);
        exp_a.push_back(19'(fb_addr));
        exp_d.push_back(pix_of(19'(src_addr)));
    endtask

    task automatic run_blit(input int src, input int w, input int h,
                            input int x, input int y, input bit hold);
        got_a.delete();
        got_d.delete();
        done_cyc   = -1;
        done_cnt   = 0;
        busy_first = -1;
        busy_last  = -1;
        @(negedge Clk);
        src_base = 19'(src);
        sprite_w = 8'(w);
        sprite_h = 8'(h);
        dst_x    = 10'(x);
        dst_y    = 10'(y);
        start    = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge Clk);
            if (!hold) start = 1'b0;
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (fb_we) begin
                got_a.push_back(fb_write_address);
                got_d.push_back(fb_data);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                start = 1'b0;
            end
            if (done_cyc >= 0 && c >= done_cyc + 6) break;
        end
        start = 1'b0;
    endtask

    task automatic verify(input string tag, input int done_exp);
        check_eq({tag, "_nwr"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), got_a[i], exp_a[i]);
            check_eq($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
        end
        check_eq({tag, "_donecyc"}, done_cyc, done_exp);
        check_eq({tag, "_donecnt"}, done_cnt, 1);
        check_eq({tag, "_busyfirst"}, busy_first, 1);
        check_eq({tag, "_busylast"}, busy_last, done_exp);
        exp_a.delete();
        exp_d.delete();
    endtask

    task automatic expect_opaque_4x2;
        add_exp(4810, 0);
`ifndef BLIT_TRANSPARENCY_EN
        add_exp(4811, 1);
`endif
        add_exp(4812, 2);
        add_exp(4813, 3);
        add_exp(5050, 256);
        add_exp(5051, 257);
        add_exp(5052, 258);
        add_exp(5053, 259);
    endtask

    initial begin
        int we_seen;
        Reset    = 1'b1;
        start    = 1'b0;
        src_base = '0;
        sprite_w = '0;
        sprite_h = '0;
        dst_x    = '0;
        dst_y    = '0;
        repeat (3) @(negedge Clk);
        check_eq("rst_we", fb_we, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rdaddr", char_read_address, 0);
        check_eq("rst_wraddr", fb_write_address, 0);
        check_eq("rst_fbdata", fb_data, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // 4x2 at (10,20); key pixel skipped only with transparency enabled.
        expect_opaque_4x2();
        run_blit(0, 4, 2, 10, 20, 1'b0);
        verify("blit4x2", 10);

        // Right-edge clip.
        add_exp(238, 100);
        add_exp(239, 101);
        run_blit(100, 4, 1, 238, 0, 1'b0);
        verify("clipright", 6);

        // Left-edge clip, negative x.
        add_exp(0, 202);
        add_exp(1, 203);
        run_blit(200, 4, 1, -2, 0, 1'b0);
        verify("clipleft", 6);

        // Top-edge clip: row at y=-1 dropped.
        add_exp(0, 261);
        add_exp(1, 262);
        add_exp(2, 263);
        run_blit(5, 3, 2, 0, -1, 1'b0);
        verify("cliptop", 8);

        // Bottom-edge clip: row at y=160 dropped.
        add_exp(38160, 10);
        add_exp(38161, 11);
        run_blit(10, 2, 2, 0, 159, 1'b0);
        verify("clipbottom", 6);

        // Zero-width sprite: no writes, done at cycle 2.
        run_blit(0, 0, 3, 5, 5, 1'b0);
        verify("zerow", 2);

        // start held high through busy and the done cycle: one blit only.
        add_exp(1205, 300);
        add_exp(1206, 301);
        run_blit(300, 2, 1, 5, 5, 1'b1);
        verify("holdstart", 4);

        // Reset in the middle of an 8x8 blit.
        @(negedge Clk);
        src_base = 19'd0;
        sprite_w = 8'd8;
        sprite_h = 8'd8;
        dst_x    = 10'd0;
        dst_y    = 10'd0;
        start    = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        check_eq("midrun_busy", busy, 1);
        check_eq("midrun_we", fb_we, 1);
        #1 Reset = 1'b1;
        #1;
        check_eq("abort_we", fb_we, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_wraddr", fb_write_address, 0);
        check_eq("abort_rdaddr", char_read_address, 0);
        repeat (2) @(negedge Clk);
        Reset   = 1'b0;
        we_seen = 0;
        done_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge Clk);
            if (fb_we) we_seen++;
            if (done) done_cnt++;
        end
        check_eq("abort_nowe", we_seen, 0);
        check_eq("abort_nodone", done_cnt, 0);
        check_eq("abort_idle", busy, 0);

        // Clean blit after the abort.
        expect_opaque_4x2();
        run_blit(0, 4, 2, 10, 20, 1'b0);
        verify("afterrst", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
